decode_issue_queue: RTL and testbench

- Receiving end of the decode-stage-2 single instruction bus. Buffers each muxed decoded instruction packet in a FIFO and presents it to the register-read/issue stage using a valid/ready handshake.
- The producer has no ready input. The queue gives it backpressure through an early stall signal and flags any overflow. Sits between decode stage 2 and register read.

---
 rtl/decode_issue_queue.sv | 175 +++++++++++++++++
 tb/tb_decode_issue_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_queue.sv
// Decoded-instruction FIFO between decode stage 2 and register read.
// The producer has no ready input, so it is throttled by a registered early stall; dropped pushes raise a sticky overflow.
module decode_issue_queue #(
    parameter int depth          = 4,
    parameter int ptrWidth       = 2,
    parameter int stallSlack     = 2,
    parameter int regWidth       = 5,
    parameter int opcodeWidth    = 6,
    parameter int XxoOpcodeWidth = 10,
    parameter int formatWidth    = 5
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      enable_i,
    input  logic [63:0]               instructionAddress_i,
    input  logic [opcodeWidth-1:0]    opcode_i,
    input  logic [XxoOpcodeWidth-1:0] xOpcode_i,
    input  logic                      xOpcodeEnable_i,
    input  logic [formatWidth-1:0]    instructionFormat_i,
    input  logic [63:0]               imm_i,
    input  logic                      immEnable_i,
    input  logic [regWidth-1:0]       reg1_i,
    input  logic [regWidth-1:0]       reg2_i,
    input  logic [regWidth-1:0]       reg3_i,
    input  logic                      reg1Enable_i,
    input  logic                      reg2Enable_i,
    input  logic                      reg3Enable_i,
    input  logic                      reg3IsImmediate_i,
    input  logic                      reg2ValOrZero_i,
    input  logic                      bit1_i,
    input  logic                      bit2_i,
    input  logic                      bit1Enable_i,
    input  logic                      bit2Enable_i,
    output logic                      stall_o,
    output logic                      overflow_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [63:0]               instructionAddress_o,
    output logic [opcodeWidth-1:0]    opcode_o,
    output logic [XxoOpcodeWidth-1:0] xOpcode_o,
    output logic                      xOpcodeEnable_o,
    output logic [formatWidth-1:0]    instructionFormat_o,
    output logic [63:0]               imm_o,
    output logic                      immEnable_o,
    output logic [regWidth-1:0]       reg1_o,
    output logic [regWidth-1:0]       reg2_o,
    output logic [regWidth-1:0]       reg3_o,
    output logic                      reg1Enable_o,
    output logic                      reg2Enable_o,
    output logic                      reg3Enable_o,
    output logic                      reg3IsImmediate_o,
    output logic                      reg2ValOrZero_o,
    output logic                      bit1_o,
    output logic                      bit2_o,
    output logic                      bit1Enable_o,
    output logic                      bit2Enable_o,
    output logic [ptrWidth:0]         count_o
);

    localparam int PKT_W = 64 + opcodeWidth + XxoOpcodeWidth + 1 + formatWidth
                         + 64 + 1 + 3 * regWidth + 3 + 2 + 4;

    localparam logic [ptrWidth:0]   DEPTH_CNT    = (ptrWidth + 1)'(depth);
    localparam logic [ptrWidth:0]   STALL_THRESH = (ptrWidth + 1)'(depth - stallSlack);
    localparam logic [ptrWidth:0]   CNT_ONE      = (ptrWidth + 1)'(1);
    localparam logic [ptrWidth-1:0] PTR_ONE      = ptrWidth'(1);

    logic [PKT_W-1:0]    mem_reg [depth];
    logic [PKT_W-1:0]    pkt_in;
    logic [PKT_W-1:0]    pkt_head;

    logic [ptrWidth-1:0] wr_ptr_reg;
    logic [ptrWidth-1:0] wr_ptr_next;
    logic [ptrWidth-1:0] rd_ptr_reg;
    logic [ptrWidth-1:0] rd_ptr_next;
    logic [ptrWidth:0]   count_reg;
    logic [ptrWidth:0]   count_next;
    logic                stall_reg;
    logic                overflow_reg;

    logic                full;
    logic                pop;
    logic                push;
    logic                drop;
    logic                write_en;
    logic [depth-1:0]    wr_sel;

    assign pkt_in = {instructionAddress_i, opcode_i, xOpcode_i, xOpcodeEnable_i,
                     instructionFormat_i, imm_i, immEnable_i,
                     reg1_i, reg2_i, reg3_i,
                     reg1Enable_i, reg2Enable_i, reg3Enable_i,
                     reg3IsImmediate_i, reg2ValOrZero_i,
                     bit1_i, bit2_i, bit1Enable_i, bit2Enable_i};

    // Head is read combinationally so a pushed packet is visible exactly one cycle later.
    assign pkt_head = mem_reg[rd_ptr_reg];

    assign {instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o,
            instructionFormat_o, imm_o, immEnable_o,
            reg1_o, reg2_o, reg3_o,
            reg1Enable_o, reg2Enable_o, reg3Enable_o,
            reg3IsImmediate_o, reg2ValOrZero_o,
            bit1_o, bit2_o, bit1Enable_o, bit2Enable_o} = pkt_head;

    assign valid_o    = (count_reg != '0);
    assign count_o    = count_reg;
    assign stall_o    = stall_reg;
    assign overflow_o = overflow_reg;

    // A full queue still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full     = (count_reg == DEPTH_CNT);
        pop      = valid_o && ready_i;
        push     = enable_i && (!full || pop);
        drop     = enable_i && full && !pop;
        write_en = push && !flush_i;

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_next = count_reg - CNT_ONE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_entry
            assign wr_sel[gi] = write_en && (wr_ptr_reg == ptrWidth'(gi));

            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    mem_reg[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    mem_reg[gi] <= pkt_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            stall_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // Stall tracks the post-update occupancy so it lines up with count_o.
            stall_reg  <= (count_next >= STALL_THRESH);
            if (drop && !flush_i) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: reset, hold, fill/overflow/drain, flush, mid-stream reset, full push+pop.
module tb_decode_issue_queue;

    logic        clk;
    logic        reset_i;
    logic        flush_i;
    logic        enable_i;
    logic [63:0] instructionAddress_i;
    logic [5:0]  opcode_i;
    logic [9:0]  xOpcode_i;
    logic        xOpcodeEnable_i;
    logic [4:0]  instructionFormat_i;
    logic [63:0] imm_i;
    logic        immEnable_i;
    logic [4:0]  reg1_i, reg2_i, reg3_i;
    logic        reg1Enable_i, reg2Enable_i, reg3Enable_i;
    logic        reg3IsImmediate_i, reg2ValOrZero_i;
    logic        bit1_i, bit2_i, bit1Enable_i, bit2Enable_i;
    logic        ready_i;

    logic        stall_o, overflow_o, valid_o;
    logic [63:0] instructionAddress_o;
    logic [5:0]  opcode_o;
    logic [9:0]  xOpcode_o;
    logic        xOpcodeEnable_o;
    logic [4:0]  instructionFormat_o;
    logic [63:0] imm_o;
    logic        immEnable_o;
    logic [4:0]  reg1_o, reg2_o, reg3_o;
    logic        reg1Enable_o, reg2Enable_o, reg3Enable_o;
    logic        reg3IsImmediate_o, reg2ValOrZero_o;
    logic        bit1_o, bit2_o, bit1Enable_o, bit2Enable_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    decode_issue_queue dut (
        .clock_i(clk), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
        .instructionAddress_i(instructionAddress_i), .opcode_i(opcode_i),
        .xOpcode_i(xOpcode_i), .xOpcodeEnable_i(xOpcodeEnable_i),
        .instructionFormat_i(instructionFormat_i), .imm_i(imm_i), .immEnable_i(immEnable_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .reg3_i(reg3_i),
        .reg1Enable_i(reg1Enable_i), .reg2Enable_i(reg2Enable_i), .reg3Enable_i(reg3Enable_i),
        .reg3IsImmediate_i(reg3IsImmediate_i), .reg2ValOrZero_i(reg2ValOrZero_i),
        .bit1_i(bit1_i), .bit2_i(bit2_i), .bit1Enable_i(bit1Enable_i), .bit2Enable_i(bit2Enable_i),
        .stall_o(stall_o), .overflow_o(overflow_o), .valid_o(valid_o), .ready_i(ready_i),
        .instructionAddress_o(instructionAddress_o), .opcode_o(opcode_o),
        .xOpcode_o(xOpcode_o), .xOpcodeEnable_o(xOpcodeEnable_o),
        .instructionFormat_o(instructionFormat_o), .imm_o(imm_o), .immEnable_o(immEnable_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
        .reg1Enable_o(reg1Enable_o), .reg2Enable_o(reg2Enable_o), .reg3Enable_o(reg3Enable_o),
        .reg3IsImmediate_o(reg3IsImmediate_o), .reg2ValOrZero_o(reg2ValOrZero_o),
        .bit1_o(bit1_o), .bit2_o(bit2_o), .bit1Enable_o(bit1Enable_o), .bit2Enable_o(bit2Enable_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [63:0] addr, input logic [5:0] op, input logic [63:0] imm,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] fmt);
        instructionAddress_i = addr;
        opcode_i             = op;
        imm_i                = imm;
        reg1_i               = r1;
        reg2_i               = r2;
        instructionFormat_i  = fmt;
        xOpcode_i            = 10'h2A5;
        xOpcodeEnable_i      = 1'b1;
        immEnable_i          = 1'b1;
        reg3_i               = 5'd31;
        reg1Enable_i         = 1'b1;
        reg2Enable_i         = 1'b1;
        reg3Enable_i         = 1'b0;
        reg3IsImmediate_i    = 1'b1;
        reg2ValOrZero_i      = 1'b0;
        bit1_i               = 1'b1;
        bit2_i               = 1'b0;
        bit1Enable_i         = 1'b1;
        bit2Enable_i         = 1'b1;
    endtask

    initial begin
        reset_i = 1'b1; flush_i = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
        set_pkt(64'h0, 6'd0, 64'h0, 5'd0, 5'd0, 5'd0);
        step(); step();
        reset_i = 1'b0;
        step();

        // Reset state
        check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_addr", instructionAddress_o, 0);
        check("rst_imm", imm_o, 0);
        check("rst_xop", xOpcode_o, 0);
        check("rst_reg3", reg3_o, 0);

        // Single D-form packet, held with ready low
        set_pkt(64'h100, 6'd14, 64'hFFFF_FFFF_FFFF_FFF0, 5'd3, 5'd0, 5'd4);
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        check("d_valid", valid_o, 1);
        check("d_count", count_o, 1);
        check("d_stall", stall_o, 0);
        check("d_opcode", opcode_o, 14);
        check("d_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFF0);
        check("d_reg1", reg1_o, 3);
        check("d_reg2", reg2_o, 0);
        check("d_reg3", reg3_o, 31);
        check("d_fmt", instructionFormat_o, 4);
        check("d_xop", xOpcode_o, 10'h2A5);
        check("d_flags", {reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o,
                          reg2ValOrZero_o, bit1_o, bit2_o, bit1Enable_o, bit2Enable_o,
                          xOpcodeEnable_o, immEnable_o}, 11'b110_10_1011_11);
        for (int i = 0; i < 5; i++) begin
            step();
            check("d_hold_addr", instructionAddress_o, 64'h100);
            check("d_hold_valid", valid_o, 1);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("d_pop_count", count_o, 0);
        check("d_pop_valid", valid_o, 0);

        // Fill four, overflow on fifth, then drain in order
        for (int i = 0; i < 4; i++) begin
            set_pkt(64'(i * 4), 6'(i + 1), 64'(i), 5'(i), 5'(i + 8), 5'd25);
            enable_i = 1'b1;
            step();
            check("fill_count", count_o, 64'(i + 1));
            check("fill_stall", stall_o, (i >= 1) ? 1 : 0);
        end
        set_pkt(64'h10, 6'd5, 64'h5, 5'd5, 5'd5, 5'd1);
        step();
        enable_i = 1'b0;
        check("ovf_flag", overflow_o, 1);
        check("ovf_count", count_o, 4);
        check("ovf_head", instructionAddress_o, 0);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", instructionAddress_o, 64'(i * 4));
            check("drain_fmt", instructionFormat_o, 25);
            step();
            check("drain_count", count_o, 64'(3 - i));
            check("drain_stall", stall_o, (3 - i >= 2) ? 1 : 0);
        end
        ready_i = 1'b0;
        check("drain_ovf_sticky", overflow_o, 1);

        // Flush with concurrent push; overflow must survive
        for (int i = 0; i < 3; i++) begin
            set_pkt(64'h40 + 64'(i * 4), 6'd7, 64'h7, 5'd1, 5'd2, 5'd3);
            enable_i = 1'b1;
            step();
        end
        check("pre_flush_count", count_o, 3);
        set_pkt(64'h4C, 6'd7, 64'h7, 5'd1, 5'd2, 5'd3);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; enable_i = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_valid", valid_o, 0);
        check("flush_stall", stall_o, 0);
        check("flush_ovf", overflow_o, 1);
        set_pkt(64'h50, 6'd9, 64'h9, 5'd9, 5'd9, 5'd9);
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        check("post_flush_valid", valid_o, 1);
        check("post_flush_count", count_o, 1);
        check("post_flush_addr", instructionAddress_o, 64'h50);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("post_flush_pop", count_o, 0);

        // Reset mid-stream with a concurrent push
        for (int i = 0; i < 3; i++) begin
            set_pkt(64'h60 + 64'(i * 4), 6'd11, 64'hAB, 5'd4, 5'd5, 5'd6);
            enable_i = 1'b1;
            step();
        end
        check("pre_rst_count", count_o, 3);
        set_pkt(64'h6C, 6'd11, 64'hAB, 5'd4, 5'd5, 5'd6);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0; enable_i = 1'b0;
        check("mrst_count", count_o, 0);
        check("mrst_valid", valid_o, 0);
        check("mrst_ovf", overflow_o, 0);
        check("mrst_stall", stall_o, 0);
        check("mrst_addr", instructionAddress_o, 0);
        check("mrst_imm", imm_o, 0);
        step();
        check("mrst_not_stored", count_o, 0);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            set_pkt(64'h20 + 64'(i * 4), 6'd2, 64'h2, 5'd2, 5'd2, 5'd2);
            enable_i = 1'b1;
            step();
        end
        check("full_count", count_o, 4);
        check("full_stall", stall_o, 1);
        set_pkt(64'h30, 6'd3, 64'h3, 5'd3, 5'd3, 5'd3);
        ready_i = 1'b1;
        step();
        enable_i = 1'b0;
        check("pp_ovf", overflow_o, 0);
        check("pp_count", count_o, 4);
        check("pp_head", instructionAddress_o, 64'h24);
        for (int i = 0; i < 4; i++) begin
            check("pp_drain_addr", instructionAddress_o, 64'h24 + 64'(i * 4));
            step();
        end
        ready_i = 1'b0;
        check("pp_empty", count_o, 0);
        check("pp_empty_valid", valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
